// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC, state encodings, exception code,
// nop encoding and the F/D payload struct.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] IMEM_LO_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI_DEF  = 32'h0000_6FFF;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [31:0] NOP          = 32'h0;

  typedef enum logic {
    FETCH_REQ  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_e;

  // One fetched instruction as it travels from F into D.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  excode;
  } fd_pkt_t;

  // Word-aligned and inside the instruction window.
  function automatic logic addr_legal(input logic [31:0] a,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (a[1:0] == 2'b00) && (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register. en loads a real instruction; bubble loads a nop
// slot that still carries the fetch PC.
module fd_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    en,
  input  logic    bubble,
  input  fd_pkt_t din,
  output fd_pkt_t dout,
  output logic    valid
);

  // Load, bubble or hold; en wins over bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout  <= '{pc: RESET_PC, instr: NOP, excode: 5'd0};
      valid <= 1'b0;
    end else if (en) begin
      dout  <= din;
      valid <= 1'b1;
    end else if (bubble) begin
      dout  <= '{pc: din.pc, instr: NOP, excode: 5'd0};
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: fetch PC register, REQ/HOLD state machine, one-entry skid
// buffer for a fetch that completes under stall, and the F/D register.
// Optional macro FETCH_ADEL_EN: illegal fetch addresses complete at once as
// a nop tagged with AdEL; the IMEM_LO/IMEM_HI bounds exist only in that build.
module fetch_stage
  import fetch_stage_pkg::*;
#(
`ifdef FETCH_ADEL_EN
  parameter logic [31:0] IMEM_LO  = IMEM_LO_DEF,
  parameter logic [31:0] IMEM_HI  = IMEM_HI_DEF,
`endif
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  output logic [31:0] F_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_valid,
  output logic [4:0]  D_excode
);

  fetch_state_e state, state_nxt;
  logic [31:0]  fpc;
  fd_pkt_t      skid, cur, fd_din, fd_q;
  logic         fetch_done, fd_en, fd_bubble, skid_ld, pc_adv;

`ifdef FETCH_ADEL_EN
  logic adel;
  assign adel       = !addr_legal(fpc, IMEM_LO, IMEM_HI);
  assign fetch_done = adel || imem_ready;
  assign cur        = '{pc: fpc, instr: adel ? NOP : imem_rdata,
                        excode: adel ? EXC_ADEL : 5'd0};
  assign imem_req   = (state == FETCH_REQ) && !adel;
`else
  assign fetch_done = imem_ready;
  assign cur        = '{pc: fpc, instr: imem_rdata, excode: 5'd0};
  assign imem_req   = (state == FETCH_REQ);
`endif

  // Next state and datapath controls; skid drains into D once stall drops.
  always_comb begin
    state_nxt = state;
    fd_en     = 1'b0;
    fd_bubble = 1'b0;
    fd_din    = cur;
    skid_ld   = 1'b0;
    pc_adv    = 1'b0;
    case (state)
      FETCH_REQ: begin
        if (!stall) begin
          if (fetch_done) begin
            fd_en  = 1'b1;
            pc_adv = 1'b1;
          end else begin
            fd_bubble = 1'b1;
          end
        end else if (fetch_done) begin
          skid_ld   = 1'b1;
          state_nxt = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (!stall) begin
          fd_en     = 1'b1;
          fd_din    = skid;
          pc_adv    = 1'b1;
          state_nxt = FETCH_REQ;
        end
      end
      default: state_nxt = FETCH_REQ;
    endcase
  end

  // State, fetch PC and skid buffer; skid is only meaningful in HOLD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH_REQ;
      fpc   <= RESET_PC;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      if (pc_adv)  fpc  <= npc;
      if (skid_ld) skid <= cur;
    end
  end

  fd_reg #(.RESET_PC(RESET_PC)) u_fd_reg (
    .clk    (clk),
    .reset  (reset),
    .en     (fd_en),
    .bubble (fd_bubble),
    .din    (fd_din),
    .dout   (fd_q),
    .valid  (D_valid)
  );

  assign F_PC      = fpc;
  assign imem_addr = fpc;
  assign D_PC      = fd_q.pc;
  assign D_Instr   = fd_q.instr;
  assign D_excode  = fd_q.excode;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the expected instruction stream is the
// chain of addresses produced by a fixed next-PC map, independent of timing.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        rdy_rand = 1'b0;
  logic [31:0] npc, F_PC, imem_addr, imem_rdata, D_PC, D_Instr;
  logic        imem_req, imem_ready, D_valid;
  logic [4:0]  D_excode;

  logic        br_en  [64];
  logic [31:0] br_tgt [64];
  exp_t        sb[$];
  logic [31:0] gen_pc;
  int          n_pass = 0, n_tot = 0, n_pop = 0;

  always #5 clk = ~clk;

  function automatic logic legal(input logic [31:0] a);
`ifdef FETCH_ADEL_EN
    return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a <= 32'h6FFF);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] a);
    if (!legal(a)) return RST_PC;
    if (br_en[a[7:2]]) return br_tgt[a[7:2]];
    return a + 32'd4;
  endfunction

  assign imem_ready = rdy_rand & imem_req;
  assign imem_rdata = mem_word(imem_addr);
  assign npc        = next_pc(F_PC);

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .npc(npc), .F_PC(F_PC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .D_PC(D_PC), .D_Instr(D_Instr),
    .D_valid(D_valid), .D_excode(D_excode)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic refill();
    exp_t e;
    while (sb.size() < 8) begin
      e.pc    = gen_pc;
      e.instr = legal(gen_pc) ? mem_word(gen_pc) : 32'h0;
      e.exc   = legal(gen_pc) ? 5'd0 : 5'd4;
      sb.push_back(e);
      gen_pc  = next_pc(gen_pc);
    end
  endtask

  task automatic step(input logic st, input logic rd);
    @(negedge clk);
    #1;
    stall    = st;
    rdy_rand = rd;
    refill();
  endtask

  // Values seen at the last rising edge, for the monitor.
  logic reset_q = 1'b0, stall_q = 1'b0, rdy_q = 1'b0;
  always @(posedge clk) begin
    reset_q <= reset;
    stall_q <= stall;
    rdy_q   <= imem_ready;
  end

  // Monitor: pops the scoreboard whenever a new instruction enters D.
  initial begin
    logic [31:0] p_fpc, p_dpc, p_di;
    logic        p_dv, in_hold, done;
    exp_t        e;
    p_fpc = 'x; p_dpc = 'x; p_di = 'x; p_dv = 1'b0; in_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_q) begin
        in_hold = 1'b0;
        chk("rst_fpc", F_PC, RST_PC);
        chk("rst_dpc", D_PC, RST_PC);
        chk("rst_dvalid", {31'd0, D_valid}, 32'd0);
        chk("rst_dinstr", D_Instr, 32'h0);
        chk("rst_exc", {27'd0, D_excode}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
      end else begin
        done    = legal(p_fpc) ? rdy_q : 1'b1;
        in_hold = stall_q ? (in_hold || done) : 1'b0;
        chk("req", {31'd0, imem_req}, {31'd0, !in_hold && legal(F_PC)});
        if (stall_q) begin
          chk("stall_fpc", F_PC, p_fpc);
          chk("stall_dpc", D_PC, p_dpc);
          chk("stall_dinstr", D_Instr, p_di);
          chk("stall_dvalid", {31'd0, D_valid}, {31'd0, p_dv});
        end else if (D_valid) begin
          if (sb.size() == 0) begin
            chk("sb_nonempty", 32'd0, 32'd1);
          end else begin
            e = sb.pop_front();
            n_pop++;
            chk("d_pc", D_PC, e.pc);
            chk("d_instr", D_Instr, e.instr);
            chk("d_exc", {27'd0, D_excode}, {27'd0, e.exc});
          end
        end else begin
          chk("bubble_instr", D_Instr, 32'h0);
          chk("bubble_dpc", D_PC, p_fpc);
        end
      end
      chk("addr_eq_fpc", imem_addr, F_PC);
      p_fpc = F_PC; p_dpc = D_PC; p_di = D_Instr; p_dv = D_valid;
    end
  end

  // Driver.
  initial begin
    for (int i = 0; i < 64; i++) begin
      br_en[i]  = ($urandom_range(0, 7) == 0);
      br_tgt[i] = $urandom_range(32'h0C00, 32'h0FFF) << 2;
`ifdef FETCH_ADEL_EN
      if ($urandom_range(0, 3) == 0)
        br_tgt[i] = br_tgt[i] + 32'($urandom_range(1, 3));
`endif
    end
    gen_pc = RST_PC;
    refill();
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    // Zero-wait memory, no stalls: one instruction per cycle.
    repeat (10) step(1'b0, 1'b1);
    repeat (400) step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 70);
    // Park in HOLD, then reset: buffered word must be discarded.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    sb.delete();
    gen_pc   = RST_PC;
    refill();
    reset    = 1'b1;
    stall    = 1'b0;
    rdy_rand = 1'b1;
    repeat (300) step($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 70);
    repeat (5) step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("progress", {31'd0, n_pop > 150}, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- F-stage of the 5-stage pipeline. Owns the fetch PC register and the F/D pipeline register, and drives a request/ready instruction-memory port.
- Consumes the next-PC value produced by the next-PC logic and feeds back F_PC.
- Presents D_PC and D_Instr to the decode stage.
- Handles hazard-unit stalls and multi-cycle memory latency without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- IMEM_LO, 32'h0000_3000, lowest legal instruction address (only used with the optional feature).
- IMEM_HI, 32'h0000_6FFF, highest legal instruction address (only used with the optional feature).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  hazard-unit stall; freezes F_PC and the F/D register.
- npc  in  32  next fetch address from the next-PC logic, valid combinationally in the same cycle.
- F_PC  out  32  current fetch address; fed back to the next-PC logic.
- imem_req  out  1  instruction read request.
- imem_addr  out  32  read address; always equals F_PC.
- imem_rdata  in  32  instruction word; valid when imem_ready=1.
- imem_ready  in  1  read completes this cycle.
- D_PC  out  32  PC of the instruction in D.
- D_Instr  out  32  instruction in D; 32'h0 (nop) when D_valid=0.
- D_valid  out  1  D holds a real instruction.
- D_excode  out  5  exception code attached to the D instruction.

Behaviour:
- Reset (reset=0 at a rising edge):
  - F_PC=RESET_PC, state=REQ, D_PC=RESET_PC, D_Instr=0, D_valid=0, D_excode=0, skid buffer empty.
  - Reset takes priority over every other input, including mid-wait and mid-hold.
- States: REQ, HOLD.
- REQ:
  - imem_req=1.
  - imem_ready=1 and stall=0: D_PC<=F_PC, D_Instr<=imem_rdata, D_valid<=1, F_PC<=npc. Stay in REQ. Throughput is one instruction per cycle for zero-wait memory.
  - imem_ready=1 and stall=1: buffer imem_rdata and F_PC in the skid buffer, go to HOLD. D and F_PC are unchanged.
  - imem_ready=0 and stall=0: insert a bubble. D_valid<=0, D_Instr<=0, D_PC<=F_PC. F_PC holds and the request stays asserted.
  - imem_ready=0 and stall=1: D, F_PC and state hold.
- HOLD:
  - imem_req=0.
  - stall=1: everything holds.
  - stall=0: D_PC<=skid PC, D_Instr<=skid instr, D_valid<=1, F_PC<=npc, go to REQ.
- Memory contract: the memory never asserts imem_ready while imem_req=0. F_PC and imem_addr stay stable while a request is outstanding.
- npc is sampled only on the cycle F_PC advances. F_PC never changes while stall=1.
- Arithmetic: none internal. The +4 and branch arithmetic live in the next-PC logic. F_PC wraps naturally at 32 bits.
- D_excode is 0 whenever the optional feature is compiled out.

Optional Feature:
- Macro: FETCH_ADEL_EN.
- Defined:
  - F_PC is illegal if F_PC[1:0]!=0 or F_PC<IMEM_LO or F_PC>IMEM_HI.
  - When F_PC is illegal, imem_req=0 and the fetch is treated as completing immediately, with a synthetic instruction 32'h0 and excode 5'd4 (AdEL).
  - The synthetic fetch follows the same stall/HOLD rules as a real one. It reaches D with D_valid=1, D_Instr=0, D_excode=4.
- Undefined: no address check, D_excode tied to 0, IMEM_LO/IMEM_HI unused.

Decomposition:
- Shared header head.v (existing project header): RESET_PC value, FETCH_REQ/FETCH_HOLD state encodings, EXC_ADEL=5'd4, NOP=32'h0.
- One sub-module, fd_reg: the F/D pipeline register with en (load) and bubble inputs, registering D_PC/D_Instr/D_valid/D_excode.
- The state machine, F_PC register and skid buffer stay in fetch_stage.

Test Plan:
- Release reset, imem_ready=1 always, npc=F_PC+4:
  - Cycle 1: D_PC=0x3000, D_valid=1.
  - Then D_PC advances by 4 each cycle: 0x3004, 0x3008.
- imem_ready low for 2 cycles at F_PC=0x3004:
  - Two bubbles (D_valid=0, D_Instr=0), F_PC stays 0x3004, imem_addr stable.
  - Then D_PC=0x3004 with the returned word.
- stall=1 on the cycle imem_ready=1 at F_PC=0x3008, held 3 cycles:
  - D holds the 0x3004 instruction, imem_req=0 in HOLD.
  - After stall drops, D_PC=0x3008 with the buffered word, exactly once.
- npc=0x3100 (taken branch) while fetching 0x300C:
  - After 0x300C reaches D, F_PC=0x3100.
  - Next D_PC=0x3100; no 0x3010 appears.
- Pull reset low while in HOLD:
  - Next edge: F_PC=0x3000, D_valid=0, state REQ, skid contents discarded.
- With FETCH_ADEL_EN, npc=0x3002:
  - imem_req=0.
  - D_PC=0x3002, D_Instr=0, D_excode=4, D_valid=1.
